cfg_stream_ctrl: RTL and testbench

- Configuration sequencer for the daisy-chained LUT/switch-box tiles.
- Accepts parallel configuration frames from a config source over a valid/ready handshake and serializes them LSB-first onto the tile bit_in_CB chain.
- Drives the prgm_b and cb_prgm_b programming strobes, counts frames, and reports completion.
- Replaces hand-sequenced strobe/counter logic with a synthesizable controller.

---
 rtl/cfg_pkg.sv | 14 +
 rtl/cfg_stream_ctrl_if.sv | 21 ++
 rtl/cfg_piso.sv | 49 ++++
 rtl/cfg_stream_ctrl.sv | 142 ++++++++++++++
 tb/tb_cfg_stream_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared state type and default sizes for the config stream controller
package cfg_pkg;

  localparam int CFG_FRAME_BITS = 26;
  localparam int CFG_NUM_FRAMES = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/cfg_stream_ctrl_if.sv
// rtl/cfg_stream_ctrl_if.sv - frame handshake from config source to controller; CFG_PARITY_EN adds frame_parity
interface cfg_stream_ctrl_if
  import cfg_pkg::*;
#(
  parameter int FRAME_BITS = CFG_FRAME_BITS
);

  logic [FRAME_BITS-1:0] frame_data;
  logic                  frame_valid;
  logic                  frame_ready;
`ifdef CFG_PARITY_EN
  logic                  frame_parity;

  modport master (output frame_data, frame_valid, frame_parity, input  frame_ready);
  modport slave  (input  frame_data, frame_valid, frame_parity, output frame_ready);
`else
  modport master (output frame_data, frame_valid, input  frame_ready);
  modport slave  (input  frame_data, frame_valid, output frame_ready);
`endif

endinterface

// File: rtl/cfg_piso.sv
// rtl/cfg_piso.sv - parallel-load, LSB-first shift register with per-frame bit counter
module cfg_piso
  import cfg_pkg::*;
#(
  parameter int FRAME_BITS = CFG_FRAME_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  shift,
  input  logic [FRAME_BITS-1:0] data,
  output logic                  bit_out,
  output logic                  last
);

  localparam int CNT_W = $clog2(FRAME_BITS);

  logic [FRAME_BITS-2:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;

  assign last = (bit_cnt == CNT_W'(FRAME_BITS - 1));

  // bit 0 goes straight to bit_out on load so it is visible the cycle after acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      bit_out <= 1'b0;
    end else if (clear) begin
      shreg   <= '0;
      bit_cnt <= '0;
      bit_out <= 1'b0;
    end else if (load) begin
      bit_out <= data[0];
      shreg   <= data[FRAME_BITS-1:1];
      bit_cnt <= '0;
    end else if (shift) begin
      if (last) begin
        bit_out <= 1'b0;
      end else begin
        bit_out <= shreg[0];
        shreg   <= {1'b0, shreg[FRAME_BITS-2:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cfg_stream_ctrl.sv
// rtl/cfg_stream_ctrl.sv - sequences config frames onto the tile chain; CFG_PARITY_EN enables frame parity check
module cfg_stream_ctrl
  import cfg_pkg::*;
#(
  parameter int FRAME_BITS = CFG_FRAME_BITS,
  parameter int NUM_FRAMES = CFG_NUM_FRAMES,
  parameter int IDX_W      = $clog2(NUM_FRAMES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  cfg_stream_ctrl_if.slave frame_if,
  output logic             bit_out,
  output logic             shift_en,
  output logic             prgm_b,
  output logic             cb_prgm_b,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] frame_idx
`ifdef CFG_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  state_t           state, state_nx;
  logic             accept, par_bad, kill, piso_last, idx_last;
  logic             prgm_b_nx, cb_prgm_b_nx, busy_nx, done_nx, shift_en_nx;
  logic [IDX_W-1:0] frame_idx_nx;

  assign frame_if.frame_ready = (state == LOAD) && !abort;
  assign accept   = frame_if.frame_ready && frame_if.frame_valid;
  assign idx_last = (frame_idx >= IDX_W'(NUM_FRAMES - 1));

`ifdef CFG_PARITY_EN
  assign par_bad = accept && (^{frame_if.frame_data, frame_if.frame_parity});
`else
  assign par_bad = 1'b0;
`endif

  // a bad-parity frame is handled exactly like an abort
  assign kill = (abort && (state != IDLE)) || par_bad;

  cfg_piso #(.FRAME_BITS(FRAME_BITS)) u_piso (
    .clk     (clk),
    .reset   (reset),
    .clear   (kill),
    .load    (accept),
    .shift   (state == SHIFT),
    .data    (frame_if.frame_data),
    .bit_out (bit_out),
    .last    (piso_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prgm_b    <= 1'b1;
      cb_prgm_b <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      shift_en  <= 1'b0;
      frame_idx <= '0;
    end else begin
      state     <= state_nx;
      prgm_b    <= prgm_b_nx;
      cb_prgm_b <= cb_prgm_b_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      shift_en  <= shift_en_nx;
      frame_idx <= frame_idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (kill) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nx = LOAD;
        LOAD:    if (accept) state_nx = SHIFT;
        SHIFT:   if (piso_last) state_nx = idx_last ? FINISH : LOAD;
        FINISH:  state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    prgm_b_nx    = prgm_b;
    cb_prgm_b_nx = cb_prgm_b;
    busy_nx      = busy;
    done_nx      = 1'b0;
    shift_en_nx  = 1'b0;
    frame_idx_nx = frame_idx;
    if (kill) begin
      prgm_b_nx    = 1'b1;
      cb_prgm_b_nx = 1'b0;
      busy_nx      = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            prgm_b_nx    = 1'b0;
            cb_prgm_b_nx = 1'b1;
            busy_nx      = 1'b1;
            frame_idx_nx = '0;
          end
        end
        LOAD: shift_en_nx = accept;
        SHIFT: begin
          shift_en_nx = !piso_last;
          if (piso_last) begin
            if (frame_idx != IDX_W'(NUM_FRAMES)) frame_idx_nx = frame_idx + 1'b1;
            if (idx_last) cb_prgm_b_nx = 1'b0;
          end
        end
        FINISH: begin
          prgm_b_nx = 1'b1;
          busy_nx   = 1'b0;
          done_nx   = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CFG_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else if (par_bad) begin
      parity_err <= 1'b1;
    end else if ((state == IDLE) && start) begin
      parity_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_cfg_stream_ctrl.sv
// tb/tb_cfg_stream_ctrl.sv - self-checking bench for cfg_stream_ctrl; CFG_PARITY_EN adds the parity scenario
module tb_cfg_stream_ctrl;
  import cfg_pkg::*;

  localparam int FB = 26;
  localparam int NF = 3;
  localparam int IW = $clog2(NF + 1);
  localparam logic [FB-1:0] F1 = 26'h0000001;
  localparam logic [FB-1:0] F2 = 26'h2C00001;
  localparam logic [FB-1:0] F3 = 26'h3400003;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic          bit_out, shift_en, prgm_b, cb_prgm_b, busy, done;
  logic [IW-1:0] frame_idx;
`ifdef CFG_PARITY_EN
  logic          parity_err;
`endif

  cfg_stream_ctrl_if #(.FRAME_BITS(FB)) fif ();

  cfg_stream_ctrl #(.FRAME_BITS(FB), .NUM_FRAMES(NF)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .frame_if  (fif),
    .bit_out   (bit_out),
    .shift_en  (shift_en),
    .prgm_b    (prgm_b),
    .cb_prgm_b (cb_prgm_b),
    .busy      (busy),
    .done      (done),
    .frame_idx (frame_idx)
`ifdef CFG_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          done_cyc = 0;
  int          done_cnt = 0;
  int          run_len = 0;
  int          cap_n = 0;
  int          runs[$];
  bit          exp_q[$];
  logic [77:0] cap = '0;
  logic        prev_done = 1'b0, prev_prgm = 1'b1, prev_cb = 1'b0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bounded wait expired (t=%0t)", name, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: expected serial bits queue plus strobe rules checked every cycle
  always @(negedge clk) begin
    if (reset) begin
      run_len   = 0;
      prev_done = 1'b0;
    end else begin
      if (shift_en) begin
        run_len++;
        if (cap_n < 78) begin
          cap[cap_n] = bit_out;
          cap_n++;
        end
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_bit: shift_en=1 with no bit pending, bit_out=%0b", bit_out);
        end else begin
          chk("serial_bit", bit_out, exp_q.pop_front());
        end
        chk("shift_cb_prgm_b", cb_prgm_b, 1);
        chk("shift_prgm_b", prgm_b, 0);
      end else begin
        if (run_len != 0) begin
          runs.push_back(run_len);
          run_len = 0;
        end
        chk("bit_out_idle", bit_out, 0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_width", prev_done, 0);
        chk("finish_prgm_b", prev_prgm, 0);
        chk("finish_cb_prgm_b", prev_cb, 0);
        chk("done_prgm_b", prgm_b, 1);
        chk("done_busy", busy, 0);
      end
      prev_done = done;
      prev_prgm = prgm_b;
      prev_cb   = cb_prgm_b;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic send_frame(input logic [FB-1:0] d, input bit bad_par);
    int n = 0;
    fif.frame_data  = d;
    fif.frame_valid = 1'b1;
`ifdef CFG_PARITY_EN
    fif.frame_parity = (^d) ^ bad_par;
`endif
    if (!bad_par) for (int i = 0; i < FB; i++) exp_q.push_back(d[i]);
    @(negedge clk);
    while (!fif.frame_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("frame_accept");
    tick();
    fif.frame_valid = 1'b0;
  endtask

  task automatic wait_done();
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_cnt == d0) fail_now("wait_done");
  endtask

  task automatic check_full_pass(input string name, input int latency);
    chk({name, "_latency"}, done_cyc - start_cyc, latency);
    chk({name, "_frame_idx"}, frame_idx, NF);
    chk({name, "_runs"}, runs.size(), 3);
    foreach (runs[i]) chk({name, "_run_len"}, runs[i], FB);
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic clean_pass(input string name);
    runs.delete();
    exp_q.delete();
    do_start();
    chk({name, "_idx_cleared"}, frame_idx, 0);
    send_frame(F1, 0);
    send_frame(F2, 0);
    send_frame(F3, 0);
    wait_done();
    check_full_pass(name, 83);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    fif.frame_data  = '0;
    fif.frame_valid = 1'b0;
`ifdef CFG_PARITY_EN
    fif.frame_parity = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_prgm_b", prgm_b, 1);
    chk("rst_cb_prgm_b", cb_prgm_b, 0);
    chk("rst_bit_out", bit_out, 0);
    chk("rst_shift_en", shift_en, 0);
    chk("rst_frame_ready", fif.frame_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_frame_idx", frame_idx, 0);
    tick();
    reset = 1'b0;
    tick();

    // nominal pass, plus literal pins on the captured stream
    runs.delete();
    cap_n = 0;
    do_start();
    chk("load_prgm_b", prgm_b, 0);
    chk("load_cb_prgm_b", cb_prgm_b, 1);
    chk("load_busy", busy, 1);
    chk("load_ready", fif.frame_ready, 1);
    send_frame(F1, 0);
    send_frame(F2, 0);
    send_frame(F3, 0);
    wait_done();
    check_full_pass("nom", 83);
    chk("nom_stream_literal", cap, {26'h3400003, 26'h2C00001, 26'h0000001});
    chk("nom_ones", $countones(cap), 10);
    tick();
    chk("nom_done_cleared", done, 0);
    chk("nom_idx_holds", frame_idx, 3);

    // underrun before frame 2
    runs.delete();
    do_start();
    send_frame(F1, 0);
    n = 0;
    while (!fif.frame_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!fif.frame_ready) fail_now("underrun_reach_load");
    for (int i = 0; i < 10; i++) begin
      chk("underrun_shift_en", shift_en, 0);
      chk("underrun_prgm_b", prgm_b, 0);
      chk("underrun_cb_prgm_b", cb_prgm_b, 1);
      chk("underrun_busy", busy, 1);
      @(negedge clk);
    end
    tick();
    send_frame(F2, 0);
    send_frame(F3, 0);
    wait_done();
    check_full_pass("underrun", 94);

    // abort while bit 13 of frame 2 is on the chain
    runs.delete();
    do_start();
    send_frame(F1, 0);
    send_frame(F2, 0);
    repeat (13) tick();
    n = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_prgm_b", prgm_b, 1);
    chk("abort_cb_prgm_b", cb_prgm_b, 0);
    chk("abort_busy", busy, 0);
    chk("abort_shift_en", shift_en, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", fif.frame_ready, 0);
    exp_q.delete();
    repeat (5) tick();
    chk("abort_no_done", done_cnt, n);
    chk("abort_runs", runs.size(), 2);
    if (runs.size() == 2) begin
      chk("abort_run0", runs[0], 26);
      chk("abort_run1", runs[1], 14);
    end
    clean_pass("after_abort");

    // asynchronous reset mid-shift of frame 2
    runs.delete();
    exp_q.delete();
    do_start();
    send_frame(F1, 0);
    send_frame(F2, 0);
    repeat (5) tick();
    chk("pre_reset_idx", frame_idx, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_prgm_b", prgm_b, 1);
    chk("async_cb_prgm_b", cb_prgm_b, 0);
    chk("async_shift_en", shift_en, 0);
    chk("async_bit_out", bit_out, 0);
    chk("async_busy", busy, 0);
    chk("async_idx", frame_idx, 0);
    exp_q.delete();
    runs.delete();
    tick();
    tick();
    reset = 1'b0;
    tick();
    clean_pass("after_reset");

    // start while busy is ignored; start coinciding with done is honoured
    runs.delete();
    exp_q.delete();
    do_start();
    send_frame(F1, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_frame(F2, 0);
    send_frame(F3, 0);
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    if (!done) fail_now("coincident_done");
    chk("busy_start_latency", cyc - start_cyc, 83);
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    chk("coinc_prgm_b", prgm_b, 0);
    chk("coinc_cb_prgm_b", cb_prgm_b, 1);
    chk("coinc_busy", busy, 1);
    chk("coinc_ready", fif.frame_ready, 1);
    chk("coinc_idx", frame_idx, 0);
    runs.delete();
    send_frame(F1, 0);
    send_frame(F2, 0);
    send_frame(F3, 0);
    wait_done();
    check_full_pass("coinc", 83);

`ifdef CFG_PARITY_EN
    // bad parity on frame 2 behaves as abort and latches parity_err
    runs.delete();
    exp_q.delete();
    do_start();
    chk("par_clear_idle", parity_err, 0);
    send_frame(F1, 0);
    send_frame(F2, 1);
    chk("par_err_set", parity_err, 1);
    chk("par_prgm_b", prgm_b, 1);
    chk("par_cb_prgm_b", cb_prgm_b, 0);
    chk("par_busy", busy, 0);
    chk("par_done", done, 0);
    chk("par_shift_en", shift_en, 0);
    repeat (4) tick();
    chk("par_err_sticky", parity_err, 1);
    chk("par_runs", runs.size(), 1);
    do_start();
    chk("par_err_cleared", parity_err, 0);
    runs.delete();
    send_frame(F1, 0);
    send_frame(F2, 0);
    send_frame(F3, 0);
    wait_done();
    check_full_pass("par_recover", 83);
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
